pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: memory-wait stalls, branch flushes,
// load-use stalls and EX operand forwarding. Define PIPE_HAZARD_STALL_CNT_EN to add the stall_cnt port.

module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [2:0]  ex_rs,
    input  logic [2:0]  ex_rt,
    input  logic        idex_memRead,
    input  logic [2:0]  idex_rd,
    input  logic        exmem_memRead,
    input  logic        exmem_memWrite,
    input  logic        exmem_regWrite,
    input  logic [2:0]  exmem_rd,
    input  logic        memwb_regWrite,
    input  logic [2:0]  memwb_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_bubble,
    output logic        mem_timeout,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  state_o
`ifdef PIPE_HAZARD_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    logic mem_busy, load_use;
    logic hz_pc_en, hz_ifid_en, hz_idex_en, hz_exmem_en;
    logic hz_ifid_flush, hz_idex_flush, hz_bubble;

    always_comb begin
        mem_busy = (exmem_memRead | exmem_memWrite) & ~mem_ready;
        load_use = idex_memRead & ((idex_rd == id_rs) | (id_uses_rt & (idex_rd == id_rt)));

        hz_pc_en      = 1'b1;
        hz_ifid_en    = 1'b1;
        hz_idex_en    = 1'b1;
        hz_exmem_en   = 1'b1;
        hz_ifid_flush = 1'b0;
        hz_idex_flush = 1'b0;
        hz_bubble     = 1'b0;
        state_d       = ST_RUN;
        wait_cnt_d    = 4'd0;

        if (mem_busy) begin
            hz_pc_en    = 1'b0;
            hz_ifid_en  = 1'b0;
            hz_idex_en  = 1'b0;
            hz_exmem_en = 1'b0;
            hz_bubble   = 1'b1;
            state_d     = ST_MEM_WAIT;
            if (state_q == ST_MEM_WAIT)
                wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
        end else if (ex_branch_taken) begin
            hz_ifid_flush = 1'b1;
            hz_idex_flush = 1'b1;
            state_d       = ST_FLUSH;
        end else if (load_use && (state_q == ST_RUN)) begin
            // Hold IF/ID and turn the ID->EX slot into a bubble until the load result exists
            hz_pc_en      = 1'b0;
            hz_ifid_en    = 1'b0;
            hz_idex_flush = 1'b1;
        end

        if (state_q == ST_ILLEGAL)
            state_d = ST_RUN;

        // wait_cnt_d counts this cycle too, so the flag rises in the same cycle the count hits 15
        timeout_d = timeout_q | ((state_q == ST_MEM_WAIT) & mem_busy & (wait_cnt_d == 4'hF));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 4'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign pc_en        = rst_n & hz_pc_en;
    assign ifid_en      = rst_n & hz_ifid_en;
    assign idex_en      = rst_n & hz_idex_en;
    assign exmem_en     = rst_n & hz_exmem_en;
    assign ifid_flush   = ~rst_n | hz_ifid_flush;
    assign idex_flush   = ~rst_n | hz_idex_flush;
    assign memwb_bubble = ~rst_n | hz_bubble;
    assign mem_timeout  = rst_n & timeout_d;
    assign state_o      = state_q;

    logic [2:0] fwd_src [2];
    logic [1:0] fwd_sel [2];

    assign fwd_src[0] = ex_rs;
    assign fwd_src[1] = ex_rt;

    // A load in EX/MEM has no data yet, so it cannot be the newest forwarding source
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] = !rst_n ? 2'b00 :
                (exmem_regWrite & ~exmem_memRead & (exmem_rd == fwd_src[gi])) ? 2'b10 :
                (memwb_regWrite & (memwb_rd == fwd_src[gi]))                  ? 2'b01 :
                                                                                 2'b00;
        end
    endgenerate

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= 16'd0;
        else if (!hz_pc_en && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per-cycle comparison against a behavioural model
// plus directed scenarios with hand-computed expectations.

module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] id_rs = 3'd0, id_rt = 3'd0, ex_rs = 3'd0, ex_rt = 3'd0;
    logic [2:0] idex_rd = 3'd0, exmem_rd = 3'd0, memwb_rd = 3'd0;
    logic       id_uses_rt = 1'b0, idex_memRead = 1'b0;
    logic       exmem_memRead = 1'b0, exmem_memWrite = 1'b0, exmem_regWrite = 1'b0;
    logic       memwb_regWrite = 1'b0, ex_branch_taken = 1'b0, mem_ready = 1'b1;

    logic       pc_en, ifid_en, idex_en, exmem_en;
    logic       ifid_flush, idex_flush, memwb_bubble, mem_timeout;
    logic [1:0] fwd_a, fwd_b, state_o;
`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt),
        .idex_memRead(idex_memRead), .idex_rd(idex_rd),
        .exmem_memRead(exmem_memRead), .exmem_memWrite(exmem_memWrite),
        .exmem_regWrite(exmem_regWrite), .exmem_rd(exmem_rd),
        .memwb_regWrite(memwb_regWrite), .memwb_rd(memwb_rd),
        .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state_o(state_o)
`ifdef PIPE_HAZARD_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the pipeline is doing, not how the controller encodes it
    bit m_waiting = 0, m_after_branch = 0, m_sticky = 0;
    int m_stall_run = 0, m_stall_cnt = 0;
    bit p_waiting = 0, p_after_branch = 0, p_sticky = 0;
    int p_stall_run = 0, p_stall_cnt = 0;

    function automatic int fwd_model(input int src);
        if (exmem_regWrite && !exmem_memRead && int'(exmem_rd) == src) return 2;
        if (memwb_regWrite && int'(memwb_rd) == src) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        bit busy, br, lu, e_to;
        int run_now, e_state;
        int e_pc, e_ifid, e_idex, e_exmem, e_ff, e_xf, e_bub;
        if (!rst_n) begin
            chk("rst_pc_en", pc_en, 0);       chk("rst_ifid_en", ifid_en, 0);
            chk("rst_idex_en", idex_en, 0);   chk("rst_exmem_en", exmem_en, 0);
            chk("rst_ifid_flush", ifid_flush, 1); chk("rst_idex_flush", idex_flush, 1);
            chk("rst_bubble", memwb_bubble, 1);   chk("rst_timeout", mem_timeout, 0);
            chk("rst_fwd_a", fwd_a, 0); chk("rst_fwd_b", fwd_b, 0); chk("rst_state", state_o, 0);
            p_waiting = 0; p_after_branch = 0; p_sticky = 0; p_stall_run = 0; p_stall_cnt = 0;
        end else begin
            busy = (exmem_memRead || exmem_memWrite) && !mem_ready;
            br   = ex_branch_taken;
            lu   = idex_memRead && (idex_rd == id_rs || (id_uses_rt && idex_rd == id_rt))
                   && !m_waiting && !m_after_branch;
            run_now = busy ? m_stall_run + 1 : 0;
            e_to    = m_sticky || (busy && run_now >= 16);
            e_state = m_waiting ? 1 : (m_after_branch ? 2 : 0);
            e_pc    = (!busy && !(lu && !br)) ? 1 : 0;
            e_ifid  = e_pc;
            e_idex  = busy ? 0 : 1;
            e_exmem = e_idex;
            e_ff    = (!busy && br) ? 1 : 0;
            e_xf    = (!busy && (br || lu)) ? 1 : 0;
            e_bub   = busy ? 1 : 0;
            chk("pc_en", pc_en, e_pc);       chk("ifid_en", ifid_en, e_ifid);
            chk("idex_en", idex_en, e_idex); chk("exmem_en", exmem_en, e_exmem);
            chk("ifid_flush", ifid_flush, e_ff); chk("idex_flush", idex_flush, e_xf);
            chk("memwb_bubble", memwb_bubble, e_bub);
            chk("mem_timeout", mem_timeout, int'(e_to));
            chk("state_o", state_o, e_state);
            chk("fwd_a", fwd_a, fwd_model(int'(ex_rs)));
            chk("fwd_b", fwd_b, fwd_model(int'(ex_rt)));
`ifdef PIPE_HAZARD_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, m_stall_cnt);
`endif
            p_waiting      = busy;
            p_after_branch = !busy && br;
            p_stall_run    = run_now;
            p_sticky       = e_to;
            p_stall_cnt    = (e_pc == 0 && m_stall_cnt < 65535) ? m_stall_cnt + 1 : m_stall_cnt;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_waiting <= 0; m_after_branch <= 0; m_sticky <= 0;
            m_stall_run <= 0; m_stall_cnt <= 0;
        end else begin
            m_waiting <= p_waiting; m_after_branch <= p_after_branch; m_sticky <= p_sticky;
            m_stall_run <= p_stall_run; m_stall_cnt <= p_stall_cnt;
        end
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic idle_inputs();
        id_rs = 3'd1; id_rt = 3'd2; id_uses_rt = 1'b0; ex_rs = 3'd1; ex_rt = 3'd2;
        idex_memRead = 1'b0; idex_rd = 3'd0;
        exmem_memRead = 1'b0; exmem_memWrite = 1'b0; exmem_regWrite = 1'b0; exmem_rd = 3'd0;
        memwb_regWrite = 1'b0; memwb_rd = 3'd0; ex_branch_taken = 1'b0; mem_ready = 1'b1;
    endtask

    initial begin
        idle_inputs();
        exmem_regWrite = 1'b1; exmem_rd = 3'd1; ex_rs = 3'd1;
        smp();
        chk("L_rst_pc_en", pc_en, 0); chk("L_rst_idex_flush", idex_flush, 1);
        chk("L_rst_bubble", memwb_bubble, 1); chk("L_rst_fwd_a", fwd_a, 0);
        $display("reset held: pc_en=%0d idex_flush=%0d fwd_a=%0d", pc_en, idex_flush, fwd_a);
        nxt(); rst_n = 1'b1;
        smp();
        chk("L_run_fwd_a", fwd_a, 2); chk("L_run_pc_en", pc_en, 1); chk("L_run_state", state_o, 0);
        $display("reset released: fwd_a=%0d state=%0d", fwd_a, state_o);

        // Load-use on rs
        nxt(); idle_inputs(); idex_memRead = 1'b1; idex_rd = 3'd3; id_rs = 3'd3;
        smp();
        chk("L_lu_pc_en", pc_en, 0); chk("L_lu_ifid_en", ifid_en, 0);
        chk("L_lu_idex_flush", idex_flush, 1); chk("L_lu_idex_en", idex_en, 1);
        $display("load-use rs: pc_en=%0d idex_flush=%0d", pc_en, idex_flush);
        nxt(); idex_memRead = 1'b0;
        smp();
        chk("L_lu_after_pc_en", pc_en, 1); chk("L_lu_after_state", state_o, 0);
        $display("after load-use: pc_en=%0d state=%0d", pc_en, state_o);

        // Load-use on rt only counts when the instruction reads rt
        nxt(); idex_memRead = 1'b1; idex_rd = 3'd5; id_rs = 3'd1; id_rt = 3'd5; id_uses_rt = 1'b0;
        smp(); chk("L_rt_unused_pc_en", pc_en, 1);
        $display("rt match, rt unused: pc_en=%0d", pc_en);
        nxt(); id_uses_rt = 1'b1;
        smp(); chk("L_rt_used_pc_en", pc_en, 0);
        $display("rt match, rt used: pc_en=%0d", pc_en);

        // Memory wait of four cycles then release
        nxt(); idle_inputs(); exmem_memRead = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nxt();
            smp();
            chk("L_mw_pc_en", pc_en, 0); chk("L_mw_exmem_en", exmem_en, 0);
            chk("L_mw_bubble", memwb_bubble, 1); chk("L_mw_state", state_o, (i == 0) ? 0 : 1);
            $display("mem wait %0d: pc_en=%0d bubble=%0d state=%0d", i, pc_en, memwb_bubble, state_o);
        end
        nxt(); mem_ready = 1'b1;
        smp();
        chk("L_rel_pc_en", pc_en, 1); chk("L_rel_idex_en", idex_en, 1);
        chk("L_rel_exmem_en", exmem_en, 1); chk("L_rel_bubble", memwb_bubble, 0);
        chk("L_rel_state", state_o, 1);
        $display("mem release: pc_en=%0d bubble=%0d state=%0d", pc_en, memwb_bubble, state_o);
        nxt(); exmem_memRead = 1'b0;
        smp(); chk("L_post_rel_state", state_o, 0);
        $display("after release: state=%0d", state_o);

        // Forwarding priority
        nxt(); idle_inputs();
        exmem_regWrite = 1'b1; exmem_rd = 3'd2; memwb_regWrite = 1'b1; memwb_rd = 3'd2;
        ex_rs = 3'd2; ex_rt = 3'd6;
        smp(); chk("L_fwd_a_exmem", fwd_a, 2); chk("L_fwd_b_none", fwd_b, 0);
        $display("fwd both match: fwd_a=%0d fwd_b=%0d", fwd_a, fwd_b);
        nxt(); exmem_memRead = 1'b1;
        smp(); chk("L_fwd_a_load", fwd_a, 1); chk("L_fwd_load_state", state_o, 0);
        $display("fwd exmem is load: fwd_a=%0d", fwd_a);
        nxt(); exmem_memRead = 1'b0; exmem_regWrite = 1'b0; ex_rt = 3'd2;
        smp(); chk("L_fwd_b_memwb", fwd_b, 1);
        $display("fwd memwb only: fwd_b=%0d", fwd_b);

        // Branch beats load-use, then the flush cycle hides load-use
        nxt(); idle_inputs(); idex_memRead = 1'b1; idex_rd = 3'd4; id_rs = 3'd4; ex_branch_taken = 1'b1;
        smp();
        chk("L_br_ifid_flush", ifid_flush, 1); chk("L_br_idex_flush", idex_flush, 1);
        chk("L_br_pc_en", pc_en, 1);
        $display("branch+load-use: ifid_flush=%0d idex_flush=%0d pc_en=%0d", ifid_flush, idex_flush, pc_en);
        nxt(); ex_branch_taken = 1'b0;
        smp();
        chk("L_fl_state", state_o, 2); chk("L_fl_pc_en", pc_en, 1); chk("L_fl_idex_flush", idex_flush, 0);
        $display("flush cycle: state=%0d pc_en=%0d", state_o, pc_en);
        nxt();
        smp(); chk("L_fl_after_state", state_o, 0); chk("L_fl_after_pc_en", pc_en, 0);
        $display("after flush: state=%0d pc_en=%0d", state_o, pc_en);
        nxt(); idex_memRead = 1'b0; ex_branch_taken = 1'b1;
        smp();
        nxt();
        smp(); chk("L_reflush_state", state_o, 2); chk("L_reflush_ifid_flush", ifid_flush, 1);
        $display("re-flush: state=%0d ifid_flush=%0d", state_o, ifid_flush);
        nxt(); ex_branch_taken = 1'b0;
        smp(); chk("L_reflush_hold", state_o, 2);
        nxt();
        smp(); chk("L_reflush_done", state_o, 0);
        $display("re-flush done: state=%0d", state_o);

        // Long wait drives the sticky timeout
        nxt(); idle_inputs(); exmem_memWrite = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) nxt();
            smp();
            chk("L_to_flag", mem_timeout, (k >= 16) ? 1 : 0);
            $display("stall %0d: mem_timeout=%0d", k, mem_timeout);
        end
        nxt(); mem_ready = 1'b1;
        smp(); chk("L_to_rel_flag", mem_timeout, 1); chk("L_to_rel_state", state_o, 1);
        $display("timeout release: mem_timeout=%0d state=%0d", mem_timeout, state_o);
        nxt(); exmem_memWrite = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nxt(); smp(); chk("L_to_sticky", mem_timeout, 1);
            $display("idle %0d: mem_timeout=%0d", k, mem_timeout);
        end
        nxt(); rst_n = 1'b0; #1;
        chk("L_to_rst", mem_timeout, 0);
        $display("reset asserted: mem_timeout=%0d", mem_timeout);
        smp(); nxt(); rst_n = 1'b1;
        smp(); chk("L_to_after_rst", mem_timeout, 0);

        // Reset in the middle of a memory wait
        nxt(); idle_inputs(); exmem_memRead = 1'b1; mem_ready = 1'b0;
        smp(); nxt(); smp(); nxt(); smp();
        chk("L_mwr_state", state_o, 1);
        #2 rst_n = 1'b0; #1;
        chk("L_mwr_pc_en", pc_en, 0); chk("L_mwr_ifid_flush", ifid_flush, 1);
        chk("L_mwr_bubble", memwb_bubble, 1); chk("L_mwr_state0", state_o, 0);
        $display("reset mid-wait: pc_en=%0d state=%0d", pc_en, state_o);
        nxt(); idle_inputs(); rst_n = 1'b1;
        smp();
        chk("L_mwr_after_state", state_o, 0); chk("L_mwr_after_to", mem_timeout, 0);
        chk("L_mwr_after_pc_en", pc_en, 1);
`ifdef PIPE_HAZARD_STALL_CNT_EN
        chk("L_mwr_stall_cnt", stall_cnt, 0);
`endif
        $display("after mid-wait reset: state=%0d mem_timeout=%0d", state_o, mem_timeout);

`ifdef PIPE_HAZARD_STALL_CNT_EN
        nxt(); exmem_memRead = 1'b1; mem_ready = 1'b0;
        smp(); nxt(); smp(); nxt(); mem_ready = 1'b1; exmem_memRead = 1'b0;
        smp(); chk("L_stall_cnt_2", stall_cnt, 2);
        $display("stall_cnt after two stalls: %0d", stall_cnt);
`endif

        nxt(); nxt(); smp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
